// File: rtl/svp_rtl_pkg.sv
// Shared state type and default constants for the capture controller.
package svp_rtl_pkg;

  localparam int unsigned SVP_WIDTH  = 14;
  localparam int unsigned SVP_DEPTH  = 16;
  localparam int unsigned SVP_TS_W   = 64;
  localparam int unsigned SVP_CNT_W  = 32;
  localparam int unsigned SVP_DEC_W  = 8;
  localparam int unsigned SVP_DROP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } svp_cap_state_e;

  // A decimation ratio of 0 behaves as 1.
  function automatic logic [SVP_DEC_W-1:0] svp_eff_decim(input logic [SVP_DEC_W-1:0] d);
    return (d == '0) ? SVP_DEC_W'(1) : d;
  endfunction

endpackage

// File: rtl/svp_sync_fifo.sv
// Single-clock FIFO with head-of-queue read; a push while full is accepted when a pop
// happens in the same cycle.
module svp_sync_fifo #(
  parameter int unsigned W     = 78,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the read port shows zero afterwards.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/svp_capture_ctrl.sv
// Triggered, decimating sample capture into a timestamped FIFO drained by a dump writer.
module svp_capture_ctrl
  import svp_rtl_pkg::*;
#(
  parameter int unsigned WIDTH = SVP_WIDTH,
  parameter int unsigned DEPTH = SVP_DEPTH,
  parameter int unsigned TS_W  = SVP_TS_W,
  parameter int unsigned CNT_W = SVP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  abort,
  input  logic [SVP_DEC_W-1:0]  decim,
  input  logic [CNT_W-1:0]      num_samp,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_vld,
  output logic [WIDTH-1:0]      dout,
  output logic [TS_W-1:0]       dout_ts,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [SVP_DROP_W-1:0] drop_cnt
);

  localparam int unsigned FW = WIDTH + TS_W;

  svp_cap_state_e        r_state;
  svp_cap_state_e        w_state_nxt;
  logic [TS_W-1:0]       r_ts;
  logic [CNT_W-1:0]      r_cap_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [SVP_DEC_W-1:0]  r_dec_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic [SVP_DROP_W-1:0] r_drop_cnt;
  logic                  w_arm_go;
  logic                  w_done_set;
  logic                  w_window;
  logic                  w_dec_hit;
  logic                  w_take;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FW-1:0]         w_fifo_dout;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_ts <= '0;
    else       r_ts <= r_ts + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // The trigger cycle itself may take a sample; the decimator counts from zero there.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_go    = 1'b0;
    w_done_set  = 1'b0;
    w_window    = 1'b0;
    w_dec_hit   = (r_dec_cnt == '0);
    w_cnt_nxt   = r_cap_cnt;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_state_nxt = ST_ARMED;
          w_arm_go    = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig) begin
          w_cnt_nxt = '0;
          w_dec_hit = 1'b1;
          if (num_samp == '0) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_CAPTURE;
            w_window    = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (r_cap_cnt >= num_samp) w_state_nxt = ST_DRAIN;
        else                       w_window    = 1'b1;
      end
      ST_DRAIN: begin
        if (w_fifo_empty) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_take = w_window && din_vld && w_dec_hit && !abort;
    if (w_take) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      if (w_cnt_nxt >= num_samp) w_state_nxt = ST_DRAIN;
    end
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_arm_go    = 1'b0;
      w_done_set  = 1'b0;
    end
  end

  assign w_pop  = dout_rdy && !w_fifo_empty;
  assign w_push = w_take && (!w_fifo_full || w_pop);
  assign w_drop = w_take && w_fifo_full && !w_pop;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cap_cnt <= '0;
      r_dec_cnt <= '0;
    end else begin
      r_cap_cnt <= w_cnt_nxt;
      if (w_take)                   r_dec_cnt <= svp_eff_decim(decim) - SVP_DEC_W'(1);
      else if (r_state == ST_ARMED) r_dec_cnt <= '0;
      else if (w_window && din_vld) r_dec_cnt <= r_dec_cnt - SVP_DEC_W'(1);
    end
  end

  // Sticky status: cleared by a fresh arm; abort keeps ovf/drop history but never leaves done set.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_arm_go) begin
        r_done     <= 1'b0;
        r_ovf      <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        if (w_drop) begin
          r_ovf <= 1'b1;
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + SVP_DROP_W'(1);
        end
        if (w_done_set) r_done <= 1'b1;
        if (abort)      r_done <= 1'b0;
      end
    end
  end

  svp_sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .i_flush (abort),
    .i_push  (w_push),
    .i_data  ({din, r_ts}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign dout     = w_fifo_dout[FW-1 -: WIDTH];
  assign dout_ts  = w_fifo_dout[TS_W-1:0];
  assign dout_vld = !w_fifo_empty;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_svp_capture_ctrl.sv
// Bench for svp_capture_ctrl: directed scenarios plus random captures against a queue-based model.
module tb_svp_capture_ctrl;

  localparam int unsigned WIDTH = 14;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 64;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rstb;
  logic             arm;
  logic             trig;
  logic             abort;
  logic [7:0]       decim;
  logic [CNT_W-1:0] num_samp;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [WIDTH-1:0] dout;
  logic [TS_W-1:0]  dout_ts;
  logic             dout_vld;
  logic             dout_rdy;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [15:0]      drop_cnt;

  always #5 clk = ~clk;

  svp_capture_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .arm      (arm),
    .trig     (trig),
    .abort    (abort),
    .decim    (decim),
    .num_samp (num_samp),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_ts  (dout_ts),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [TS_W-1:0]  t;
  } smp_t;

  int checks   = 0;
  int failures = 0;

  // Reference: m is the capture phase (0 idle, 1 armed, 2 capturing, 3 draining).
  smp_t        mq[$];
  smp_t        got[$];
  int          m = 0;
  int          k = 0;
  int          n_taken = 0;
  bit          m_done = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  logic [63:0] m_ts = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int   pre;
    int   dd;
    bit   pop;
    bit   push;
    bit   cap;
    smp_t s;
    if (dout_vld && dout_rdy) begin
      s.d = dout;
      s.t = dout_ts;
      got.push_back(s);
    end
    @(posedge clk);
    pre  = mq.size();
    pop  = (pre > 0) && dout_rdy;
    push = 1'b0;
    cap  = 1'b0;
    dd   = (decim == 8'd0) ? 1 : int'(decim);
    s.d  = din;
    s.t  = m_ts;
    if (abort) begin
      mq.delete();
      m      = 0;
      m_done = 1'b0;
    end else begin
      case (m)
        0: if (arm) begin
             m = 1; m_done = 1'b0; m_ovf = 1'b0; m_drop = 0;
           end
        1: if (trig) begin
             k = 0; n_taken = 0;
             if (num_samp == '0) m = 3;
             else begin m = 2; cap = 1'b1; end
           end
        2: cap = 1'b1;
        3: if (pre == 0) begin m = 0; m_done = 1'b1; end
        default: ;
      endcase
      if (cap && din_vld) begin
        if (k % dd == 0) begin
          n_taken++;
          if (pre - int'(pop) >= int'(DEPTH)) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
          end else begin
            push = 1'b1;
          end
          if (n_taken >= int'(num_samp)) m = 3;
        end
        k++;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(s);
    end
    m_ts = m_ts + 64'd1;
    #1;
    chk("dout_vld", 64'(dout_vld), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("dout", 64'(dout), 64'(mq[0].d));
      chk("dout_ts", dout_ts, mq[0].t);
    end
    chk("busy", 64'(busy), 64'(m != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    arm = 1'b0; trig = 1'b0; abort = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dout_ts", dout_ts, 64'd0);
    chk("rst_dout_vld", 64'(dout_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    mq.delete(); got.delete();
    m = 0; m_done = 1'b0; m_ovf = 1'b0; m_drop = 0; m_ts = '0;
    repeat (2) @(posedge clk);
    #2 rstb = 1'b1;
  endtask

  task automatic run_until_idle(input bit din_ctr, input bit rdy_on_drain, input int budget);
    int n;
    n = 0;
    while (m != 0 && n < budget) begin
      if (din_ctr) din = WIDTH'(m_ts);
      else         din = WIDTH'($urandom);
      if (rdy_on_drain) dout_rdy = (m == 3);
      step();
      trig = 1'b0;
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic wait_ts(input logic [63:0] t);
    for (int i = 0; i < 200 && m_ts != t; i++) begin
      din = WIDTH'(m_ts);
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b1; arm = 1'b0; trig = 1'b0; abort = 1'b0;
    decim = 8'd1; num_samp = '0; din = '0; din_vld = 1'b0; dout_rdy = 1'b0;
    #2;
    do_reset();

    // decim=1, 4 samples, trigger when ts=10, din follows the counter
    decim = 8'd1; num_samp = 32'd4; dout_rdy = 1'b1; din_vld = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    wait_ts(64'd10);
    trig = 1'b1;
    run_until_idle(1'b1, 1'b0, 60);
    chk("s1_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        chk("s1_din", 64'(got[i].d), 64'(10 + i));
        chk("s1_ts", got[i].t, 64'(10 + i));
      end
    end
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_ovf", 64'(ovf), 64'd0);

    // decim=3, 3 samples, trigger at ts=20
    do_reset();
    decim = 8'd3; num_samp = 32'd3; dout_rdy = 1'b1; din_vld = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    wait_ts(64'd20);
    trig = 1'b1;
    run_until_idle(1'b1, 1'b0, 60);
    chk("s2_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk("s2_ts", got[i].t, 64'(20 + 3 * i));
    end

    // 20 samples into a 16-deep FIFO with the reader stalled until draining
    got.delete();
    decim = 8'd1; num_samp = 32'd20; dout_rdy = 1'b0; din_vld = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1;
    run_until_idle(1'b0, 1'b1, 120);
    chk("s3_count", 64'(got.size()), 64'd16);
    chk("s3_ovf", 64'(ovf), 64'd1);
    chk("s3_drop", 64'(drop_cnt), 64'd4);
    chk("s3_done", 64'(done), 64'd1);

    // zero-length capture
    got.delete();
    num_samp = '0; dout_rdy = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    chk("s4_cleared", 64'(ovf), 64'd0);
    trig = 1'b1; step(); trig = 1'b0;
    step();
    chk("s4_done", 64'(done), 64'd1);
    chk("s4_no_out", 64'(got.size()), 64'd0);

    // abort after 5 of 10 taken with 3 still buffered
    got.delete();
    decim = 8'd1; num_samp = 32'd10; dout_rdy = 1'b0; din_vld = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    step();
    dout_rdy = 1'b1; step(); step();
    dout_rdy = 1'b0; step();
    chk("s5_busy_pre", 64'(busy), 64'd1);
    chk("s5_vld_pre", 64'(dout_vld), 64'd1);
    abort = 1'b1; din_vld = 1'b0; step(); abort = 1'b0;
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_vld", 64'(dout_vld), 64'd0);
    chk("s5_done", 64'(done), 64'd0);

    // abort keeps overflow history; the next arm clears it
    num_samp = 32'd20; dout_rdy = 1'b0; din_vld = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    repeat (17) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("s5_ovf_kept", 64'(ovf), 64'd1);
    chk("s5_drop_kept", 64'(drop_cnt), 64'd2);
    chk("s5_vld_flushed", 64'(dout_vld), 64'd0);
    arm = 1'b1; step(); arm = 1'b0;
    chk("s5_ovf_clr", 64'(ovf), 64'd0);
    chk("s5_drop_clr", 64'(drop_cnt), 64'd0);
    abort = 1'b1; step(); abort = 1'b0;

    // reset in the middle of a capture
    decim = 8'd1; num_samp = 32'd10; dout_rdy = 1'b1; din_vld = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    step(); step();
    do_reset();
    dout_rdy = 1'b1; din_vld = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    step(); step();
    chk("s6_first_ts", (got.size() > 0) ? got[0].t : 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_until_idle(1'b0, 1'b0, 60);

    // random captures against the reference
    for (int it = 0; it < 40; it++) begin
      got.delete();
      decim    = 8'($urandom_range(0, 4));
      num_samp = 32'($urandom_range(0, 24));
      arm      = 1'b1;
      for (int c = 0; c < 600; c++) begin
        din      = WIDTH'($urandom);
        din_vld  = ($urandom_range(0, 3) != 0);
        dout_rdy = ($urandom_range(0, 3) != 0);
        trig     = ($urandom_range(0, 2) == 0);
        abort    = ($urandom_range(0, 199) == 0);
        if (c > 0) arm = ($urandom_range(0, 15) == 0) && (m != 0);
        step();
        if (m == 0) break;
      end
      arm = 1'b0; trig = 1'b0; abort = 1'b0;
      chk("rand_idle", 64'(busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
